// File: rtl/quad_decoder.sv
// quad_decoder: x4 quadrature decoder with a wrapping up/down position count.
// Phase pins A/B are synchronized, optionally glitch-filtered, and decoded
// into step/direction updates of a WIDTH-bit position counter.
// Optional feature macro: QUAD_DEBOUNCE_EN (per-phase debounce filter).
module quad_decoder #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clear,
  output logic [WIDTH-1:0] pos,
  output logic             dir,
  output logic             step,
  output logic             err,
  output logic [WIDTH-1:0] pos_oe,
  output logic             osc_en
);

  // Two flops is the least that makes the asynchronous pins safe to sample.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

`ifdef QUAD_DEBOUNCE_EN
  localparam int FILTER_DELAY = DEBOUNCE_CYCLES;
`else
  // Without the filter DEBOUNCE_CYCLES contributes no settling time.
  localparam int FILTER_DELAY = 0 * DEBOUNCE_CYCLES;
`endif

  // INIT lets the pin state propagate through every stage before it is trusted.
  localparam int              INIT_WAIT = SYNC_N + FILTER_DELAY;
  localparam logic [15:0]     INIT_LAST = 16'(INIT_WAIT);
  localparam logic [WIDTH-1:0] POS_ONE  = WIDTH'(1);

  typedef enum logic {INIT, RUN} state_t;

  state_t           state_q;
  logic [15:0]      initCnt_q;
  logic [1:0]       prev_q;
  logic [WIDTH-1:0] pos_q;
  logic             dir_q;
  logic             step_q;
  logic             err_q;
  logic [WIDTH-1:0] posOe_q;

  logic [SYNC_N-1:0] syncA_q;
  logic [SYNC_N-1:0] syncB_q;
  logic              aSync;
  logic              bSync;
  logic [1:0]        cur;
  logic [1:0]        phaseDelta;

  // Shift each asynchronous phase pin through its synchronizer chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      syncA_q <= '0;
      syncB_q <= '0;
    end else begin
      syncA_q <= {syncA_q[SYNC_N-2:0], enc_a};
      syncB_q <= {syncB_q[SYNC_N-2:0], enc_b};
    end
  end

  assign aSync = syncA_q[SYNC_N-1];
  assign bSync = syncB_q[SYNC_N-1];

`ifdef QUAD_DEBOUNCE_EN
  localparam logic [15:0] DB_LAST = 16'((DEBOUNCE_CYCLES < 1) ? 0 : DEBOUNCE_CYCLES - 1);

  logic        filtA_q;
  logic        filtB_q;
  logic [15:0] dbA_q;
  logic [15:0] dbB_q;

  // Accept a new phase level only after it has differed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      filtA_q <= 1'b0;
      filtB_q <= 1'b0;
      dbA_q   <= '0;
      dbB_q   <= '0;
    end else begin
      if (aSync != filtA_q) begin
        if (dbA_q >= DB_LAST) begin
          filtA_q <= aSync;
          dbA_q   <= '0;
        end else begin
          dbA_q <= dbA_q + 16'd1;
        end
      end else begin
        dbA_q <= '0;
      end
      if (bSync != filtB_q) begin
        if (dbB_q >= DB_LAST) begin
          filtB_q <= bSync;
          dbB_q   <= '0;
        end else begin
          dbB_q <= dbB_q + 16'd1;
        end
      end else begin
        dbB_q <= '0;
      end
    end
  end

  assign cur = {filtA_q, filtB_q};
`else
  assign cur = {aSync, bSync};
`endif

  // Position of a phase pair along the up sequence 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] phaseIdx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b10:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // 1 = one step up, 3 = one step down, 2 = both pins changed, 0 = no change.
  assign phaseDelta = phaseIdx(cur) - phaseIdx(prev_q);

  // Decoder FSM: settle in INIT, then count steps and flag illegal jumps in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= INIT;
      initCnt_q <= '0;
      prev_q    <= 2'b00;
      pos_q     <= '0;
      dir_q     <= 1'b1;
      step_q    <= 1'b0;
      err_q     <= 1'b0;
      posOe_q   <= '0;
    end else begin
      posOe_q <= '1;
      step_q  <= 1'b0;
      case (state_q)
        INIT: begin
          if (initCnt_q == INIT_LAST) begin
            prev_q  <= cur;
            state_q <= RUN;
          end else begin
            initCnt_q <= initCnt_q + 16'd1;
          end
        end
        RUN: begin
          prev_q <= cur;
          if (clear) begin
            pos_q <= '0;
            err_q <= 1'b0;
          end else begin
            case (phaseDelta)
              2'd1: begin
                pos_q  <= pos_q + POS_ONE;
                dir_q  <= 1'b1;
                step_q <= 1'b1;
              end
              2'd3: begin
                pos_q  <= pos_q - POS_ONE;
                dir_q  <= 1'b0;
                step_q <= 1'b1;
              end
              2'd2: err_q <= 1'b1;
              default: ;
            endcase
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign pos    = pos_q;
  assign dir    = dir_q;
  assign step   = step_q;
  assign err    = err_q;
  assign pos_oe = posOe_q;
  assign osc_en = 1'b1;

endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: table-driven, scripted and randomized checks of quad_decoder.
// The reference model walks the quadrature cycle as an index and moves a
// signed position by whole steps.
module tb_quad_decoder;

  localparam int WIDTH = 4;
  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int MODV  = 1 << WIDTH;
`ifdef QUAD_DEBOUNCE_EN
  localparam int LAT     = SYNC + DEB;
  localparam int MINHOLD = DEB + 1;
  localparam int GLITCH_STEPS = 0;
`else
  localparam int LAT     = SYNC;
  localparam int MINHOLD = 1;
  localparam int GLITCH_STEPS = 2;
`endif
  localparam int SETTLE = LAT + 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             enc_a;
  logic             enc_b;
  logic             clear;
  logic [WIDTH-1:0] pos;
  logic             dir;
  logic             step;
  logic             err;
  logic [WIDTH-1:0] pos_oe;
  logic             osc_en;

  int errors = 0;
  int checks = 0;
  int stepCount = 0;

  int modelPos;
  int modelDir;
  int modelErr;
  int modelIdx;
  int modelSteps;
  logic [1:0] upSeq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  typedef struct {
    logic [1:0] pins;
    logic       clr;
    int         expPos;
    int         expDir;
    int         expErr;
    int         expSteps;
  } vec_t;

  vec_t vecs [10];

  quad_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk    (clk),
    .reset  (reset),
    .enc_a  (enc_a),
    .enc_b  (enc_b),
    .clear  (clear),
    .pos    (pos),
    .dir    (dir),
    .step   (step),
    .err    (err),
    .pos_oe (pos_oe),
    .osc_en (osc_en)
  );

  always #10 clk = ~clk;

  // Count step pulses, sampled mid-cycle.
  always @(negedge clk) if (step === 1'b1) stepCount++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] pins, input logic clr);
    @(negedge clk);
    enc_a = pins[1];
    enc_b = pins[0];
    clear = clr;
  endtask

  task automatic settle();
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic moveModel(input int mv);
    modelIdx = (modelIdx + mv + 4) % 4;
    if (mv == 1) begin
      modelPos = (modelPos + 1) % MODV;
      modelDir = 1;
      modelSteps++;
    end else if (mv == -1) begin
      modelPos = (modelPos + MODV - 1) % MODV;
      modelDir = 0;
      modelSteps++;
    end else if (mv == 2) begin
      modelErr = 1;
    end
  endtask

  task automatic driveMove(input int mv, input int hold);
    moveModel(mv);
    applyStimulus(upSeq[modelIdx], 1'b0);
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic clearPulse();
    applyStimulus(upSeq[modelIdx], 1'b1);
    @(negedge clk);
    clear = 1'b0;
    modelPos = 0;
    modelErr = 0;
  endtask

  task automatic checkModel(input string tag, input int base);
    checkOutput({tag, " pos"}, int'(pos), modelPos);
    checkOutput({tag, " dir"}, int'(dir), modelDir);
    checkOutput({tag, " err"}, int'(err), modelErr);
    checkOutput({tag, " steps"}, stepCount - base, modelSteps);
  endtask

  task automatic doReset(input logic [1:0] pins);
    @(negedge clk);
    reset = 1'b1;
    clear = 1'b0;
    enc_a = pins[1];
    enc_b = pins[0];
    repeat (3) @(negedge clk);
    checkOutput("reset pos", int'(pos), 0);
    checkOutput("reset dir", int'(dir), 1);
    checkOutput("reset step", int'(step), 0);
    checkOutput("reset err", int'(err), 0);
    checkOutput("reset pos_oe", int'(pos_oe), 0);
    checkOutput("reset osc_en", int'(osc_en), 1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("pos_oe after release", int'(pos_oe), MODV - 1);
    repeat (LAT + 6) @(negedge clk);
    modelPos = 0;
    modelDir = 1;
    modelErr = 0;
    modelSteps = 0;
    modelIdx = 0;
    for (int i = 0; i < 4; i++) if (upSeq[i] == pins) modelIdx = i;
  endtask

  initial begin
    int base;
    int firstEdge;
    int mv;
    int r;

    vecs[0] = '{2'b10, 1'b0, 1,  1, 0, 1};
    vecs[1] = '{2'b11, 1'b0, 2,  1, 0, 1};
    vecs[2] = '{2'b10, 1'b0, 1,  0, 0, 1};
    vecs[3] = '{2'b00, 1'b0, 0,  0, 0, 1};
    vecs[4] = '{2'b01, 1'b0, 15, 0, 0, 1};
    vecs[5] = '{2'b00, 1'b0, 0,  1, 0, 1};
    vecs[6] = '{2'b11, 1'b0, 0,  1, 1, 0};
    vecs[7] = '{2'b01, 1'b0, 1,  1, 1, 1};
    vecs[8] = '{2'b01, 1'b1, 0,  1, 0, 0};
    vecs[9] = '{2'b11, 1'b0, 15, 0, 0, 1};

    reset = 1'b1;
    clear = 1'b0;
    enc_a = 1'b0;
    enc_b = 1'b0;

    // Table-driven sequence of mixed steps, an illegal jump and a clear.
    doReset(2'b00);
    for (int i = 0; i < 10; i++) begin
      base = stepCount;
      applyStimulus(vecs[i].pins, vecs[i].clr);
      if (vecs[i].clr) begin
        @(negedge clk);
        clear = 1'b0;
      end
      settle();
      checkOutput($sformatf("vec%0d pos", i), int'(pos), vecs[i].expPos);
      checkOutput($sformatf("vec%0d dir", i), int'(dir), vecs[i].expDir);
      checkOutput($sformatf("vec%0d err", i), int'(err), vecs[i].expErr);
      checkOutput($sformatf("vec%0d steps", i), stepCount - base, vecs[i].expSteps);
    end

    // Full up rotation with wrap.
    doReset(2'b00);
    base = stepCount;
    for (int i = 0; i < 20; i++) begin
      driveMove(1, LAT + 2);
      checkOutput($sformatf("rot%0d pos", i), int'(pos), (i + 1) % MODV);
      checkOutput($sformatf("rot%0d dir", i), int'(dir), 1);
    end
    settle();
    checkModel("rotation", base);
    checkOutput("rotation final pos", int'(pos), 4);

    // Down wrap from zero.
    doReset(2'b00);
    base = stepCount;
    driveMove(-1, 1);
    settle();
    checkModel("down wrap", base);
    checkOutput("down wrap pos", int'(pos), MODV - 1);

    // Illegal jump at pos 3 with pins at 00, then clear.
    doReset(2'b00);
    driveMove(1, MINHOLD);
    settle();
    clearPulse();
    for (int i = 0; i < 3; i++) driveMove(1, MINHOLD);
    settle();
    checkOutput("pre-illegal pos", int'(pos), 3);
    base = stepCount;
    modelSteps = 0;
    driveMove(2, 1);
    settle();
    checkModel("illegal", base);
    checkOutput("illegal err", int'(err), 1);
    clearPulse();
    settle();
    checkModel("after clear", base);

    // Clear arriving in the same cycle as a valid up step.
    driveMove(1, MINHOLD);
    driveMove(1, MINHOLD);
    settle();
    base = stepCount;
    modelIdx = (modelIdx + 1) % 4;
    applyStimulus(upSeq[modelIdx], 1'b0);
    repeat (LAT) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkOutput("collision step", int'(step), 0);
    checkOutput("collision pos", int'(pos), 0);
    modelPos = 0;
    modelSteps = 0;
    settle();
    checkModel("collision", base);

    // Reset mid-count at 7, pins held at 11 through INIT.
    doReset(2'b00);
    for (int i = 0; i < 8; i++) driveMove(1, MINHOLD);
    driveMove(-1, MINHOLD);
    settle();
    checkOutput("pre-reset pos", int'(pos), 7);
    checkOutput("pre-reset dir", int'(dir), 0);
    doReset(2'b11);
    base = stepCount;
    settle();
    checkModel("after INIT", base);

    // Latency from capture edge to step.
    firstEdge = -1;
    moveModel(1);
    applyStimulus(upSeq[modelIdx], 1'b0);
    for (int j = 1; j <= LAT + 4; j++) begin
      @(negedge clk);
      if (step === 1'b1 && firstEdge < 0) firstEdge = j - 1;
    end
    checkOutput("latency edges", firstEdge, LAT);
    settle();
    checkModel("latency", base);

    // Two-cycle pulse on A.
    base = stepCount;
    applyStimulus(upSeq[modelIdx] ^ 2'b10, 1'b0);
    @(negedge clk);
    applyStimulus(upSeq[modelIdx], 1'b0);
    settle();
    settle();
    checkOutput("glitch pos", int'(pos), modelPos);
    checkOutput("glitch steps", stepCount - base, GLITCH_STEPS);
    checkOutput("glitch err", int'(err), 0);

    // Randomized bursts against the model.
    doReset(2'b00);
    base = stepCount;
    for (int b = 0; b < 60; b++) begin
      for (int m = 0; m < int'($urandom_range(1, 4)); m++) begin
        r = int'($urandom_range(0, 9));
        if (r < 4) mv = 1;
        else if (r < 8) mv = -1;
        else if (r == 8) mv = 0;
        else mv = 2;
        driveMove(mv, MINHOLD + int'($urandom_range(0, 2)));
      end
      settle();
      checkModel($sformatf("rand%0d", b), base);
      if ($urandom_range(0, 7) == 0) begin
        clearPulse();
        settle();
        checkModel($sformatf("rand%0d clear", b), base);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
